toy_bus_dsplit_node_ack_dtcm: RTL
=================================

// Module: toy_bus_dsplit_node_ack_dtcm
// PURPOSE
//  Response-side splitter for the DTCM node: the return path of the 2:1 request arbiter in front of the DTCM.
//  Takes the single DTCM response stream and routes each beat back to initiator port 0 or 1 by its tgt_id.
//  tgt_id of a response equals the src_id of the originating request.
//  Per-port buffering decouples a stalled initiator from the DTCM for up to FIFO_DEPTH beats.
//  Unroutable beats are dropped and reported.
// PARAMETERS
//  DATA_W      256    response data width
//  ID_W        4      src_id/tgt_id width
//  SB_W        32     sideband width
//  PORT0_ID    4'd0   tgt_id routed to out0
//  PORT1_ID    4'd1   tgt_id routed to out1 (must differ from PORT0_ID)
//  FIFO_DEPTH  2      entries per output FIFO; power of 2, >=2
// PORTS
//  clk          in   1       clock
//  rst_n        in   1       async active-low reset
//  in_vld       in   1       DTCM response valid
//  in_rdy       out  1       response accepted when in_vld&&in_rdy
//  in_data      in   DATA_W  read data
//  in_opcode    in   1       opcode echoed from request
//  in_src_id    in   ID_W    responder id
//  in_tgt_id    in   ID_W    destination initiator id
//  in_sideband  in   SB_W    sideband echoed from request
//  outN_vld     out  1       N=0,1: response valid to initiator N
//  outN_rdy     in   1       initiator N ready
//  outN_data/opcode/src_id/tgt_id/sideband  out  as in_*  FIFO head fields
//  err_vld      out  1       one-cycle pulse: unroutable beat dropped
//  err_id       out  ID_W    tgt_id of the last dropped beat
//  err_cnt      out  8       saturating drop count
// BEHAVIOUR
//  - One clock; reset is asynchronous and active-low (rst_n): FIFO pointers/counts=0, outN_vld=0,
//    err_vld=0, err_id=0, err_cnt=0. Reset mid-transfer discards all buffered beats; no replay.
//  - Decode (comb): hit0 = in_tgt_id==PORT0_ID, hit1 = in_tgt_id==PORT1_ID, miss = ~hit0&~hit1.
//  - in_rdy = (hit0 & ~full0) | (hit1 & ~full1) | miss. Depends on in_tgt_id, not on in_vld.
//  - Push: beat (data, opcode, src_id, tgt_id, sideband) goes into FIFO N on in_vld&&in_rdy&&hitN.
//  - Pop: FIFO N pops on outN_vld&&outN_rdy. outN_vld = ~emptyN. outN_* = head entry.
//    outN_* are don't-care while outN_vld=0.
//  - Latency: a beat accepted in cycle t is visible on outN_vld in cycle t+1 at the earliest. No comb bypass.
//  - Full: in_rdy uses the registered full flag. A push into a full FIFO is never accepted,
//    even if the same FIFO pops in that cycle, so there is one bubble at full.
//  - Simultaneous push/pop on a non-full, non-empty FIFO: count unchanged, pointers both advance.
//  - Pointers wrap mod FIFO_DEPTH. A separate count register (log2(DEPTH)+1 bits) gives full/empty.
//  - Ordering: strict FIFO per output. No ordering relation between out0 and out1.
//  - An out0 stall never blocks out1 traffic unless the head-of-line input beat targets out0
//    and FIFO0 is full. Input is in-order, so HOL blocking at the input is accepted.
//  - Miss: the beat is consumed (in_rdy=1) and dropped.
//    Next cycle: err_vld=1 and err_id=in_tgt_id, and err_cnt increments, saturating at 8'hFF.
//    Back-to-back misses give err_vld high on consecutive cycles.
//  - outN_vld must stay asserted, with stable fields, until outN_rdy is seen (AXI-style valid hold).
// STRUCTURE
//  - toy_bus_pkg: DATA_W/ID_W/SB_W widths, node id constants (DTCM_PORT0_ID, DTCM_PORT1_ID),
//    and the packed ToyBusAck field order {sideband,tgt_id,src_id,opcode,data} used as the FIFO word.
//  - Sub-module: toy_bus_cmn_sync_fifo #(WIDTH, DEPTH), with push/pop/full/empty/head, instanced once per output.
//  - Top level holds the decode, in_rdy, and the error pulse/id/counter registers.
// TESTING
//  1 Reset: assert rst_n=0 mid-stream with FIFO0 holding 2 beats -> out0_vld=out1_vld=0,
//    err_cnt=0, in_rdy=1 after release.
//  2 Routing: tgt_id=0 data=256'hA5.. then tgt_id=1 data=256'h5A.. with both rdy=1 ->
//    out0 gets A5 at t+1 and out1 gets 5A at t+2, all fields bit-exact.
//  3 Backpressure: out0_rdy=0, send 3 beats tgt_id=0 -> first 2 accepted, in_rdy=0 on the 3rd.
//    Raise out0_rdy -> order 1,2,3 preserved, 3rd accepted one cycle after the first pop.
//  4 Independence: out0_rdy=0 with FIFO0 full, send tgt_id=1 beats -> accepted and delivered on out1 each cycle.
//  5 Error: 300 beats with tgt_id=4'hF -> in_rdy=1 throughout, err_vld one pulse per beat,
//    err_id=4'hF, err_cnt saturates at 255. No out*_vld.
//  6 Random: 10k beats, random tgt_id in {0,1,7}, random rdy ->
//    scoreboard matches per-port order and the drop count (min 255).

Source files
------------

// File: rtl/toy_bus_pkg.sv
// Shared toy-bus widths, DTCM node port ids and the response (ack) beat layout.
// The packed ack struct is the word stored in the splitter's per-port FIFOs.
package toy_bus_pkg;

    localparam int DATA_W = 256;
    localparam int ID_W   = 4;
    localparam int SB_W   = 32;

    localparam logic [ID_W-1:0] DTCM_PORT0_ID = 4'd0;
    localparam logic [ID_W-1:0] DTCM_PORT1_ID = 4'd1;

    // Field order, MSB first: {sideband, tgt_id, src_id, opcode, data}.
    typedef struct packed {
        logic [SB_W-1:0]   sideband;
        logic [ID_W-1:0]   tgt_id;
        logic [ID_W-1:0]   src_id;
        logic              opcode;
        logic [DATA_W-1:0] data;
    } toy_bus_ack_t;

    localparam int ACK_W = $bits(toy_bus_ack_t);

endpackage

// File: rtl/toy_bus_cmn_sync_fifo.sv
// Single-clock FIFO with registered occupancy count; head is the oldest entry.
// Pushes while full and pops while empty are ignored.
module toy_bus_cmn_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [WIDTH-1:0] head_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (cnt_q == CNT_W'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign head_o  = mem_q[rd_ptr_q];

    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    // DEPTH is a power of two, so pointer wrap is plain binary overflow.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        if (do_push && !do_pop)      cnt_d = cnt_q + CNT_W'(1);
        else if (!do_push && do_pop) cnt_d = cnt_q - CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data_i;
    end

endmodule

// File: rtl/toy_bus_dsplit_node_ack_dtcm.sv
// DTCM response splitter: routes each response beat to initiator port 0 or 1 by tgt_id,
// buffering per port; beats addressed to neither port are dropped and reported.
module toy_bus_dsplit_node_ack_dtcm #(
    parameter int              DATA_W     = toy_bus_pkg::DATA_W,
    parameter int              ID_W       = toy_bus_pkg::ID_W,
    parameter int              SB_W       = toy_bus_pkg::SB_W,
    parameter logic [ID_W-1:0] PORT0_ID   = toy_bus_pkg::DTCM_PORT0_ID,
    parameter logic [ID_W-1:0] PORT1_ID   = toy_bus_pkg::DTCM_PORT1_ID,
    parameter int              FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    // Handshake on every port: a beat moves on a cycle where vld && rdy; vld holds with
    // stable fields until taken. in_rdy depends on in_tgt_id but never on in_vld.
    input  logic              in_vld,
    output logic              in_rdy,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_opcode,
    input  logic [ID_W-1:0]   in_src_id,
    input  logic [ID_W-1:0]   in_tgt_id,
    input  logic [SB_W-1:0]   in_sideband,
    output logic              out0_vld,
    input  logic              out0_rdy,
    output logic [DATA_W-1:0] out0_data,
    output logic              out0_opcode,
    output logic [ID_W-1:0]   out0_src_id,
    output logic [ID_W-1:0]   out0_tgt_id,
    output logic [SB_W-1:0]   out0_sideband,
    output logic              out1_vld,
    input  logic              out1_rdy,
    output logic [DATA_W-1:0] out1_data,
    output logic              out1_opcode,
    output logic [ID_W-1:0]   out1_src_id,
    output logic [ID_W-1:0]   out1_tgt_id,
    output logic [SB_W-1:0]   out1_sideband,
    output logic              err_vld,
    output logic [ID_W-1:0]   err_id,
    output logic [7:0]        err_cnt
);

    localparam int WORD_W = SB_W + 2 * ID_W + 1 + DATA_W;

    logic              hit0, hit1, miss;
    logic              full0, full1, empty0, empty1;
    logic              fire;
    logic [WORD_W-1:0] in_word, head0, head1;
    logic              err_vld_q, err_vld_d;
    logic [ID_W-1:0]   err_id_q, err_id_d;
    logic [7:0]        err_cnt_q, err_cnt_d;

    assign hit0 = (in_tgt_id == PORT0_ID);
    assign hit1 = (in_tgt_id == PORT1_ID);
    assign miss = ~hit0 & ~hit1;

    // Full flags come from the registered count: a full FIFO refuses a push even when it pops.
    assign in_rdy  = (hit0 & ~full0) | (hit1 & ~full1) | miss;
    assign fire    = in_vld & in_rdy;
    assign in_word = {in_sideband, in_tgt_id, in_src_id, in_opcode, in_data};

    toy_bus_cmn_sync_fifo #(.WIDTH(WORD_W), .DEPTH(FIFO_DEPTH)) u_fifo0 (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (fire & hit0),
        .push_data_i (in_word),
        .pop_i       (out0_vld & out0_rdy),
        .full_o      (full0),
        .empty_o     (empty0),
        .head_o      (head0)
    );

    toy_bus_cmn_sync_fifo #(.WIDTH(WORD_W), .DEPTH(FIFO_DEPTH)) u_fifo1 (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (fire & hit1),
        .push_data_i (in_word),
        .pop_i       (out1_vld & out1_rdy),
        .full_o      (full1),
        .empty_o     (empty1),
        .head_o      (head1)
    );

    assign out0_vld = ~empty0;
    assign out1_vld = ~empty1;
    assign {out0_sideband, out0_tgt_id, out0_src_id, out0_opcode, out0_data} = head0;
    assign {out1_sideband, out1_tgt_id, out1_src_id, out1_opcode, out1_data} = head1;

    always_comb begin
        err_vld_d = fire & miss;
        err_id_d  = err_id_q;
        err_cnt_d = err_cnt_q;
        if (fire && miss) begin
            err_id_d = in_tgt_id;
            if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_vld_q <= 1'b0;
            err_id_q  <= '0;
            err_cnt_q <= 8'd0;
        end else begin
            err_vld_q <= err_vld_d;
            err_id_q  <= err_id_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_vld = err_vld_q;
    assign err_id  = err_id_q;
    assign err_cnt = err_cnt_q;

endmodule
